// File: rtl/cpu_types_pkg.sv
// A0 processor shared types.
// ISA encodings plus multicycle control additions.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDIU = 6'h09,
    SLTI  = 6'h0a,
    SLTIU = 6'h0b,
    ANDI  = 6'h0c,
    ORI   = 6'h0d,
    XORI  = 6'h0e,
    LUI   = 6'h0f,
    LW    = 6'h23,
    SW    = 6'h2b,
    HALT  = 6'h3f
  } opcode_t;

  typedef enum logic [5:0] {
    SLL  = 6'h00,
    SRL  = 6'h02,
    JR   = 6'h08,
    ADD  = 6'h20,
    ADDU = 6'h21,
    SUB  = 6'h22,
    SUBU = 6'h23,
    AND  = 6'h24,
    OR   = 6'h25,
    XOR  = 6'h26,
    NOR  = 6'h27,
    SLT  = 6'h2a,
    SLTU = 6'h2b
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;

  typedef enum logic [2:0] {
    MC_FETCH  = 3'd0,
    MC_DECODE = 3'd1,
    MC_EXEC   = 3'd2,
    MC_MEM    = 3'd3,
    MC_WB     = 3'd4,
    MC_HALT   = 3'd5,
    MC_ERROR  = 3'd6
  } mc_state_t;

  localparam logic [2:0] PCSRC_RS   = 3'd0;
  localparam logic [2:0] PCSRC_JUMP = 3'd1;
  localparam logic [2:0] PCSRC_BR   = 3'd2;
  localparam logic [2:0] PCSRC_PC4  = 3'd4;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src;
    logic       alu_src2;
    logic       ext_op;
    aluop_t     alu_ctr;
    logic       is_jump;
    logic       is_jal;
    logic       is_jr;
    logic       is_branch;
    logic       is_beq;
    logic       is_load;
    logic       is_store;
    logic       is_halt;
    logic       is_alu;
    logic       is_nop;
  } mc_dec_t;

endpackage

// File: rtl/control_unit_if.sv
// Control unit bundle between arbiter, datapath and FSM.
// mc_control is the multicycle controller's view.
interface control_unit_if;
  import cpu_types_pkg::*;

  logic [31:0] instruction;
  logic        ihit;
  logic        dhit;
  logic        zero;
  logic        iREN;
  logic        dREN;
  logic        dWEN;
  logic        IRWr;
  logic        PCWr;
  logic        RegWr;
  logic [1:0]  RegDst;
  logic [1:0]  MemToReg;
  logic [1:0]  ALUSrc;
  logic        ALUSrc2;
  logic        ExtOp;
  aluop_t      ALUctr;
  logic [2:0]  PCSrc;
  mc_state_t   state;
  logic        halt;
  logic        timeout_err;

  modport mc_control (
    input  instruction, ihit, dhit, zero,
    output iREN, dREN, dWEN, IRWr, PCWr, RegWr,
    output RegDst, MemToReg, ALUSrc, ALUSrc2,
    output ExtOp, ALUctr, PCSrc, state,
    output halt, timeout_err
  );
endinterface

// File: rtl/mc_decode.sv
// Field extraction and per-opcode static selects.
// Purely combinational; state gating lives in the top.
module mc_decode
  import cpu_types_pkg::*;
(
  input  logic [31:0] instruction,
  output mc_dec_t     dec
);

  opcode_t op;
  funct_t  fn;

  assign op = opcode_t'(instruction[31:26]);
  assign fn = funct_t'(instruction[5:0]);

  always_comb begin
    dec        = '0;
    dec.is_nop = (instruction == '0);
    unique case (op)
      RTYPE: begin
        dec.reg_dst = 2'd1;
        dec.is_alu  = 1'b1;
        unique case (fn)
          SLL: begin
            dec.alu_ctr  = ALU_SLL;
            dec.alu_src2 = 1'b1;
          end
          SRL: begin
            dec.alu_ctr  = ALU_SRL;
            dec.alu_src2 = 1'b1;
          end
          JR: begin
            dec.is_jr  = 1'b1;
            dec.is_alu = 1'b0;
          end
          ADD, ADDU: dec.alu_ctr = ALU_ADD;
          SUB, SUBU: dec.alu_ctr = ALU_SUB;
          AND:       dec.alu_ctr = ALU_AND;
          OR:        dec.alu_ctr = ALU_OR;
          XOR:       dec.alu_ctr = ALU_XOR;
          NOR:       dec.alu_ctr = ALU_NOR;
          SLT:       dec.alu_ctr = ALU_SLT;
          SLTU:      dec.alu_ctr = ALU_SLTU;
          default:   dec.is_alu  = 1'b0;
        endcase
      end
      J: dec.is_jump = 1'b1;
      JAL: begin
        dec.is_jal     = 1'b1;
        dec.reg_dst    = 2'd2;
        dec.mem_to_reg = 2'd2;
      end
      BEQ, BNE: begin
        dec.is_branch = 1'b1;
        dec.is_beq    = (op == BEQ);
        dec.alu_ctr   = ALU_SUB;
        dec.ext_op    = 1'b1;
      end
      ADDIU, SLTI, SLTIU: begin
        dec.is_alu  = 1'b1;
        dec.alu_src = 2'd1;
        dec.ext_op  = 1'b1;
        dec.alu_ctr = (op == ADDIU) ? ALU_ADD :
                      (op == SLTI)  ? ALU_SLT : ALU_SLTU;
      end
      ANDI, ORI, XORI: begin
        dec.is_alu  = 1'b1;
        dec.alu_src = 2'd1;
        dec.alu_ctr = (op == ANDI) ? ALU_AND :
                      (op == ORI)  ? ALU_OR  : ALU_XOR;
      end
      LUI: begin
        dec.is_alu  = 1'b1;
        dec.alu_src = 2'd2;
        dec.alu_ctr = ALU_OR;
      end
      LW, SW: begin
        dec.is_load    = (op == LW);
        dec.is_store   = (op == SW);
        dec.mem_to_reg = (op == LW) ? 2'd1 : 2'd0;
        dec.alu_src    = 2'd1;
        dec.ext_op     = 1'b1;
        dec.alu_ctr    = ALU_ADD;
      end
      HALT:    dec.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM for the A0 core.
// Sequences FETCH/DECODE/EXEC/MEM/WB with memory timeout.
module mc_control_unit
  import cpu_types_pkg::*;
#(
  parameter int WAIT_W   = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      instruction,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             zero,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic             IRWr,
  output logic             PCWr,
  output logic             RegWr,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic [1:0]       ALUSrc,
  output logic             ALUSrc2,
  output logic             ExtOp,
  output aluop_t           ALUctr,
  output logic [2:0]       PCSrc,
  output mc_state_t        state,
  output logic             halt,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count
);

  mc_dec_t           dec;
  mc_state_t         state_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_n;
  logic              wait_last;
  logic              retire;
  logic              sel_on;

  mc_decode u_dec (
    .instruction (instruction),
    .dec         (dec)
  );

  // Last wait cycle: no hit now means the count reaches WAIT_MAX.
  assign wait_last = (wait_cnt == WAIT_W'(WAIT_MAX - 1));

  always_comb begin
    state_n = state;
    iREN    = 1'b0;
    dREN    = 1'b0;
    dWEN    = 1'b0;
    IRWr    = 1'b0;
    PCWr    = 1'b0;
    RegWr   = 1'b0;
    PCSrc   = PCSRC_PC4;
    unique case (state)
      MC_FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          IRWr    = 1'b1;
          PCWr    = 1'b1;
          state_n = MC_DECODE;
        end else if (wait_last) begin
          state_n = MC_ERROR;
        end
      end
      MC_DECODE: begin
        unique case (1'b1)
          dec.is_halt: state_n = MC_HALT;
          dec.is_jump: begin
            PCWr    = 1'b1;
            PCSrc   = PCSRC_JUMP;
            state_n = MC_FETCH;
          end
          dec.is_jal: begin
            PCWr    = 1'b1;
            PCSrc   = PCSRC_JUMP;
            state_n = MC_WB;
          end
          dec.is_jr: begin
            PCWr    = 1'b1;
            PCSrc   = PCSRC_RS;
            state_n = MC_FETCH;
          end
          default: state_n = MC_EXEC;
        endcase
      end
      MC_EXEC: begin
        unique case (1'b1)
          dec.is_branch: begin
            PCWr    = (dec.is_beq == zero);
            PCSrc   = PCWr ? PCSRC_BR : PCSRC_PC4;
            state_n = MC_FETCH;
          end
          dec.is_load, dec.is_store: state_n = MC_MEM;
          dec.is_alu: state_n = MC_WB;
          default:    state_n = MC_FETCH;
        endcase
      end
      MC_MEM: begin
        dWEN = dec.is_store;
        dREN = !dec.is_store;
        if (dhit) begin
          state_n = dec.is_store ? MC_FETCH : MC_WB;
        end else if (wait_last) begin
          state_n = MC_ERROR;
        end
      end
      MC_WB: begin
        RegWr   = !dec.is_nop;
        state_n = MC_FETCH;
      end
      MC_HALT, MC_ERROR: ;
      default: state_n = MC_FETCH;
    endcase
  end

  always_comb begin
    wait_n = '0;
    if (state_n == state &&
        (state == MC_FETCH || state == MC_MEM)) begin
      wait_n = wait_cnt + WAIT_W'(1);
    end
  end

  assign retire = (state_n == MC_FETCH) &&
                  (state != MC_FETCH);

  assign sel_on   = state inside {MC_DECODE, MC_EXEC,
                                  MC_MEM, MC_WB};
  assign RegDst   = sel_on ? dec.reg_dst    : 2'd0;
  assign MemToReg = sel_on ? dec.mem_to_reg : 2'd0;
  assign ALUSrc   = sel_on ? dec.alu_src    : 2'd0;
  assign ALUSrc2  = sel_on & dec.alu_src2;
  assign ExtOp    = sel_on & dec.ext_op;
  assign ALUctr   = sel_on ? dec.alu_ctr : ALU_SLL;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= MC_FETCH;
      wait_cnt    <= '0;
      instr_count <= '0;
      halt        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      if (retire && !(&instr_count)) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      if (state == MC_HALT) begin
        halt <= 1'b1;
      end
      if (state == MC_ERROR) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-cycle scoreboard of
// expected states/enables plus per-scenario checks.
module tb_mc_control_unit;
  import cpu_types_pkg::*;

  localparam int WMAX = 15;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] instruction = '0;
  logic        ihit = 1'b0;
  logic        dhit = 1'b0;
  logic        zero = 1'b0;

  logic        a_iREN, a_dREN, a_dWEN, a_IRWr, a_PCWr, a_RegWr;
  logic [1:0]  a_RegDst, a_MemToReg, a_ALUSrc;
  logic        a_ALUSrc2, a_ExtOp, a_halt, a_timeout_err;
  aluop_t      a_ALUctr;
  logic [2:0]  a_PCSrc;
  mc_state_t   a_state;
  logic [31:0] a_instr_count;

  logic        b_iREN, b_dREN, b_dWEN, b_IRWr, b_PCWr, b_RegWr;
  logic [1:0]  b_RegDst, b_MemToReg, b_ALUSrc;
  logic        b_ALUSrc2, b_ExtOp, b_halt, b_timeout_err;
  aluop_t      b_ALUctr;
  logic [2:0]  b_PCSrc;
  mc_state_t   b_state;
  logic [1:0]  b_instr_count;

  mc_control_unit #(.WAIT_W(4), .WAIT_MAX(WMAX), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .instruction(instruction),
    .ihit(ihit), .dhit(dhit), .zero(zero),
    .iREN(a_iREN), .dREN(a_dREN), .dWEN(a_dWEN),
    .IRWr(a_IRWr), .PCWr(a_PCWr), .RegWr(a_RegWr),
    .RegDst(a_RegDst), .MemToReg(a_MemToReg),
    .ALUSrc(a_ALUSrc), .ALUSrc2(a_ALUSrc2),
    .ExtOp(a_ExtOp), .ALUctr(a_ALUctr), .PCSrc(a_PCSrc),
    .state(a_state), .halt(a_halt),
    .timeout_err(a_timeout_err),
    .instr_count(a_instr_count)
  );

  mc_control_unit #(.WAIT_W(4), .WAIT_MAX(WMAX), .CNT_W(2)) dut_sat (
    .CLK(CLK), .nRST(nRST), .instruction(instruction),
    .ihit(ihit), .dhit(dhit), .zero(zero),
    .iREN(b_iREN), .dREN(b_dREN), .dWEN(b_dWEN),
    .IRWr(b_IRWr), .PCWr(b_PCWr), .RegWr(b_RegWr),
    .RegDst(b_RegDst), .MemToReg(b_MemToReg),
    .ALUSrc(b_ALUSrc), .ALUSrc2(b_ALUSrc2),
    .ExtOp(b_ExtOp), .ALUctr(b_ALUctr), .PCSrc(b_PCSrc),
    .state(b_state), .halt(b_halt),
    .timeout_err(b_timeout_err),
    .instr_count(b_instr_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    mc_state_t   st;
    logic [8:0]  en;
    logic [5:0]  sel;
    logic [1:0]  ht;
    logic [31:0] ins;
    logic        ih;
    logic        dh;
    logic        z;
    bit          chk;
    int          cnt;
  } exp_t;

  exp_t        q[$];
  int          n_run = 0;
  int          n_fail = 0;
  int          retired = 0;
  logic [31:0] p_ins;
  logic        p_z;
  logic [5:0]  p_sel;

  localparam logic [8:0] EN0 = 9'b000000_100;

  function automatic logic [8:0] en9(
    logic i, logic dr, logic dw, logic ir,
    logic pw, logic rw, logic [2:0] ps);
    return {i, dr, dw, ir, pw, rw, ps};
  endfunction

  function automatic bit alu_known(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00)
      return fn inside {6'h00, 6'h02, [6'h20:6'h27], 6'h2a, 6'h2b};
    return op inside {[6'h09:6'h0f]};
  endfunction

  task automatic push(mc_state_t st, logic [8:0] en,
                      logic ih, logic dh, bit chk, logic [1:0] ht);
    exp_t e;
    e.st = st; e.en = en; e.ih = ih; e.dh = dh;
    e.chk = chk; e.ht = ht; e.ins = p_ins; e.z = p_z;
    e.sel = p_sel; e.cnt = retired;
    q.push_back(e);
  endtask

  // fin: 0 retired, 1 halted, 2 timed out
  task automatic plan(input logic [31:0] ins, input int iw,
                      input int dw, input logic z, output int fin);
    logic [5:0] op, fn;
    logic [1:0] rd, mt, as;
    bit ld, st, tk;
    op = ins[31:26];
    fn = ins[5:0];
    fin = 0;
    rd = (op == 6'h00) ? 2'd1 : (op == 6'h03) ? 2'd2 : 2'd0;
    mt = (op == 6'h23) ? 2'd1 : (op == 6'h03) ? 2'd2 : 2'd0;
    as = (op == 6'h0f) ? 2'd2 :
         (op inside {[6'h09:6'h0e], 6'h23, 6'h2b}) ? 2'd1 : 2'd0;
    p_ins = ins; p_z = z; p_sel = {rd, mt, as};
    for (int i = 0; i < iw && i < WMAX; i++)
      push(MC_FETCH, en9(1,0,0,0,0,0,4), 0, 0, 0, 2'b00);
    if (iw >= WMAX) begin fin = 2; return; end
    push(MC_FETCH, en9(1,0,0,1,1,0,4), 1, 0, 0, 2'b00);
    if (op == 6'h3f) begin
      push(MC_DECODE, EN0, 0, 0, 1, 2'b00);
      fin = 1;
      return;
    end
    if (op == 6'h02 || (op == 6'h00 && fn == 6'h08)) begin
      push(MC_DECODE, en9(0,0,0,0,1,0,(op == 6'h02) ? 3'd1 : 3'd0),
           0, 0, 1, 2'b00);
      retired++;
      return;
    end
    if (op == 6'h03) begin
      push(MC_DECODE, en9(0,0,0,0,1,0,1), 0, 0, 1, 2'b00);
      push(MC_WB, en9(0,0,0,0,0,1,4), 0, 0, 1, 2'b00);
      retired++;
      return;
    end
    push(MC_DECODE, EN0, 0, 0, 1, 2'b00);
    if (op == 6'h04 || op == 6'h05) begin
      tk = (op == 6'h04) ? z : !z;
      push(MC_EXEC, en9(0,0,0,0,tk,0,tk ? 3'd2 : 3'd4),
           0, 0, 1, 2'b00);
      retired++;
      return;
    end
    push(MC_EXEC, EN0, 0, 0, 1, 2'b00);
    ld = (op == 6'h23);
    st = (op == 6'h2b);
    if (ld || st) begin
      for (int i = 0; i < dw && i < WMAX; i++)
        push(MC_MEM, en9(0,ld,st,0,0,0,4), 0, 0, 1, 2'b00);
      if (dw >= WMAX) begin fin = 2; return; end
      push(MC_MEM, en9(0,ld,st,0,0,0,4), 0, 1, 1, 2'b00);
      if (st) begin retired++; return; end
    end else if (!alu_known(op, fn)) begin
      retired++;
      return;
    end
    push(MC_WB, en9(0,0,0,0,0,ins != 0,4), 0, 0, 1, 2'b00);
    retired++;
  endtask

  task automatic push_stuck(mc_state_t st, int n, logic [1:0] ht);
    push(st, EN0, 1, 1, 0, 2'b00);
    for (int i = 1; i < n; i++) push(st, EN0, 1, 1, 0, ht);
  endtask

  // Scoreboard: drive each cycle's stimulus, pop and compare.
  task automatic run_queue(input int n);
    exp_t e;
    logic [8:0] en;
    logic [1:0] sat;
    while (q.size() != 0 && n > 0) begin
      n--;
      e = q.pop_front();
      instruction = e.ins; ihit = e.ih; dhit = e.dh; zero = e.z;
      #1;
      en = {a_iREN, a_dREN, a_dWEN, a_IRWr, a_PCWr, a_RegWr, a_PCSrc};
      sat = (e.cnt > 3) ? 2'd3 : 2'(e.cnt);
      n_run++;
      if (a_state !== e.st) begin
        n_fail++;
        $display("FAIL sb_state ins=%h: got %0d want %0d",
                 e.ins, a_state, e.st);
      end
      n_run++;
      if (en !== e.en) begin
        n_fail++;
        $display("FAIL sb_enables ins=%h st=%0d: got %b want %b",
                 e.ins, e.st, en, e.en);
      end
      n_run++;
      if ({a_halt, a_timeout_err} !== e.ht) begin
        n_fail++;
        $display("FAIL sb_sticky ins=%h: got %b want %b",
                 e.ins, {a_halt, a_timeout_err}, e.ht);
      end
      n_run++;
      if (a_instr_count !== 32'(e.cnt) || b_instr_count !== sat) begin
        n_fail++;
        $display("FAIL sb_count ins=%h: got %0d/%0d want %0d/%0d",
                 e.ins, a_instr_count, b_instr_count, e.cnt, sat);
      end
      if (e.chk) begin
        n_run++;
        if ({a_RegDst, a_MemToReg, a_ALUSrc} !== e.sel) begin
          n_fail++;
          $display("FAIL sb_selects ins=%h st=%0d: got %b want %b",
                   e.ins, e.st, {a_RegDst, a_MemToReg, a_ALUSrc}, e.sel);
        end
      end
      @(negedge CLK);
    end
  endtask

  task automatic do_reset();
    #2 nRST = 1'b0;
    ihit = 1'b0; dhit = 1'b0; zero = 1'b0;
    q.delete();
    @(negedge CLK);
    nRST = 1'b1;
    retired = 0;
  endtask

  task automatic test_reset();
    logic [8:0] en;
    nRST = 1'b0;
    instruction = 32'h2402_0005;
    repeat (2) @(negedge CLK);
    #1;
    en = {a_iREN, a_dREN, a_dWEN, a_IRWr, a_PCWr, a_RegWr, a_PCSrc};
    n_run++;
    if (a_state !== MC_FETCH || en !== en9(1,0,0,0,0,0,4)) begin
      n_fail++;
      $display("FAIL reset_ctrl: got st=%0d en=%b want 0 %b",
               a_state, en, en9(1,0,0,0,0,0,4));
    end
    n_run++;
    if ({a_RegDst, a_MemToReg, a_ALUSrc, a_ALUSrc2, a_ExtOp} !== 8'd0
        || a_ALUctr !== ALU_SLL) begin
      n_fail++;
      $display("FAIL reset_selects: got %b/%0d want 0",
               {a_RegDst, a_MemToReg, a_ALUSrc, a_ALUSrc2, a_ExtOp},
               a_ALUctr);
    end
    n_run++;
    if (a_instr_count !== 0 || b_instr_count !== 0 ||
        a_halt !== 1'b0 || a_timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got cnt=%0d h=%b t=%b want 0 0 0",
               a_instr_count, a_halt, a_timeout_err);
    end
    @(negedge CLK);
    nRST = 1'b1;
    retired = 0;
  endtask

  task automatic test_alu();
    int fin;
    plan(32'h2402_0005, 0, 0, 0, fin);
    plan(32'h0022_1821, 0, 0, 0, fin);
    plan(32'h0000_0000, 1, 0, 0, fin);
    plan(32'h3c01_1234, 2, 0, 0, fin);
    plan(32'h3421_0ff0, 0, 0, 0, fin);
    plan(32'hf800_0000, 0, 0, 0, fin);
    plan(32'h0000_003f, 0, 0, 0, fin);
    run_queue(3);
    n_run++;
    if (a_ALUctr !== ALU_ADD || a_ExtOp !== 1'b1) begin
      n_fail++;
      $display("FAIL addiu_exec_alu: got %0d/%b want %0d/1",
               a_ALUctr, a_ExtOp, ALU_ADD);
    end
    run_queue(1000);
  endtask

  task automatic test_jump();
    int fin;
    plan(32'h0800_0010, 0, 0, 0, fin);
    plan(32'h03e0_0008, 3, 0, 0, fin);
    plan(32'h0c00_0010, 0, 0, 0, fin);
    run_queue(1000);
  endtask

  task automatic test_branch();
    int fin;
    plan(32'h1022_0003, 0, 0, 1'b1, fin);
    plan(32'h1022_0003, 0, 0, 1'b0, fin);
    plan(32'h1422_0003, 0, 0, 1'b1, fin);
    plan(32'h1422_0003, 0, 0, 1'b0, fin);
    run_queue(1000);
  endtask

  task automatic test_mem();
    int fin;
    plan(32'h8c22_0004, 0, 2, 0, fin);
    plan(32'h8c22_0004, 0, 0, 0, fin);
    plan(32'hac22_0004, 2, 0, 0, fin);
    plan(32'hac22_0004, 0, 14, 0, fin);
    run_queue(1000);
  endtask

  task automatic test_timeout();
    int fin;
    do_reset();
    plan(32'h2402_0005, 14, 0, 0, fin);
    plan(32'h0022_1821, 14, 0, 0, fin);
    plan(32'h2402_0005, 15, 0, 0, fin);
    push_stuck(MC_ERROR, 3, 2'b01);
    run_queue(1000);
    n_run++;
    if (fin !== 2 || a_timeout_err !== 1'b1 || a_iREN !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_timeout: got t=%b iREN=%b want 1 0",
               a_timeout_err, a_iREN);
    end
    do_reset();
    plan(32'hac22_0004, 0, 15, 0, fin);
    push_stuck(MC_ERROR, 2, 2'b01);
    run_queue(1000);
    n_run++;
    if (a_timeout_err !== 1'b1 || a_dWEN !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_timeout: got t=%b dWEN=%b want 1 0",
               a_timeout_err, a_dWEN);
    end
  endtask

  task automatic test_halt();
    int fin;
    do_reset();
    plan(32'h2402_0005, 0, 0, 0, fin);
    plan(32'hffff_ffff, 1, 0, 0, fin);
    push_stuck(MC_HALT, 3, 2'b10);
    run_queue(1000);
    #2 nRST = 1'b0;
    #1;
    n_run++;
    if (a_halt !== 1'b0 || a_state !== MC_FETCH || a_iREN !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_reset: got h=%b st=%0d iREN=%b want 0 0 1",
               a_halt, a_state, a_iREN);
    end
    @(negedge CLK);
    nRST = 1'b1;
    retired = 0;
  endtask

  task automatic test_async_reset();
    int fin;
    do_reset();
    plan(32'h0800_0010, 0, 0, 0, fin);
    plan(32'h2402_0005, 0, 0, 0, fin);
    run_queue(4);
    #2 nRST = 1'b0;
    #1;
    n_run++;
    if (a_state !== MC_FETCH || a_RegWr !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got st=%0d RegWr=%b want 0 0",
               a_state, a_RegWr);
    end
    q.delete();
    @(negedge CLK);
    nRST = 1'b1;
    retired = 0;
    plan(32'h0800_0010, 0, 0, 0, fin);
    run_queue(1000);
  endtask

  task automatic test_saturation();
    int fin;
    do_reset();
    for (int i = 0; i < 5; i++) plan(32'h0800_0010, 0, 0, 0, fin);
    plan(32'h2402_0005, 0, 0, 0, fin);
    run_queue(1000);
    #1;
    n_run++;
    if (a_instr_count !== 32'd6 || b_instr_count !== 2'd3) begin
      n_fail++;
      $display("FAIL saturation: got %0d/%0d want 6/3",
               a_instr_count, b_instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jump();
    test_branch();
    test_mem();
    test_timeout();
    test_halt();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

endmodule
